// File: rtl/mul_div_unit_pkg.sv
// Shared CPU constants: M-extension funct3 encodings and the mul/div sequencer states.
package mul_div_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the RV M extension.
// Both algorithms run on operand magnitudes through one shared adder/subtractor;
// signs are restored in FIX. Divide-by-zero and signed overflow finish at accept.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [TAGW-1:0] tag_in,
    input  logic            flush,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] tag_out
);

    localparam int unsigned CNTW = $clog2(XLEN + 1);
    localparam int unsigned SUMW = XLEN + 2;

    md_state_e         r_state;
    md_state_e         w_next_state;
    logic [CNTW-1:0]   r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [TAGW-1:0]   r_tag;
    logic [XLEN-1:0]   r_result;
    logic [TAGW-1:0]   r_tag_out;

    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_div_zero;
    logic              w_overflow;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_x;
    logic [SUMW-1:0]   w_y;
    logic [SUMW-1:0]   w_sum;
    logic              w_sub;
    logic              w_borrow;
    logic [XLEN:0]     w_mul_hi;
    logic [2*XLEN-1:0] w_step;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign done     = (r_state == ST_DONE);
    assign result   = r_result;
    assign tag_out  = r_tag_out;
    assign w_accept = start && ready && !flush;

    // Operand decode at accept: signedness, magnitudes, result sign and special cases
    always_comb begin
        w_a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        w_b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        w_a_neg       = w_a_signed && a[XLEN-1];
        w_b_neg       = w_b_signed && b[XLEN-1];
        w_a_mag       = w_a_neg ? (~a + XLEN'(1)) : a;
        w_b_mag       = w_b_neg ? (~b + XLEN'(1)) : b;
        w_neg         = (op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero    = op[2] && (b == '0);
        w_overflow    = ((op == OP_DIV) || (op == OP_REM)) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
        w_special     = w_div_zero || w_overflow;
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = op[1] ? a : '1;
        end else if (w_overflow) begin
            w_special_res = op[1] ? '0 : a;
        end
    end

    // One radix-2 step: add multiplicand on multiplier LSB, or trial-subtract divisor
    always_comb begin
        w_hi     = r_acc[2*XLEN-1:XLEN];
        w_lo     = r_acc[XLEN-1:0];
        w_sub    = r_op[2];
        w_x      = w_sub ? {w_hi, w_lo[XLEN-1]} : {1'b0, w_hi};
        w_y      = {2'b00, r_opb};
        w_sum    = {1'b0, w_x} + (w_sub ? ~w_y : w_y) + SUMW'(w_sub);
        w_borrow = w_sum[SUMW-1];
        w_mul_hi = w_lo[0] ? w_sum[XLEN:0] : w_x;
        if (w_sub) begin
            w_step = {(w_borrow ? w_x[XLEN-1:0] : w_sum[XLEN-1:0]), w_lo[XLEN-2:0], ~w_borrow};
        end else begin
            w_step = {w_mul_hi, w_lo[XLEN-1:1]};
        end
    end

    // Sign correction and half/quotient/remainder selection
    always_comb begin
        w_prod    = r_neg ? (~r_acc + (2*XLEN)'(1)) : r_acc;
        w_rem     = r_neg ? (~r_acc[2*XLEN-1:XLEN] + XLEN'(1)) : r_acc[2*XLEN-1:XLEN];
        w_fix_res = w_prod[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:           w_fix_res = w_prod[XLEN-1:0];
            OP_DIV, OP_DIVU:  w_fix_res = w_prod[XLEN-1:0];
            OP_REM, OP_REMU:  w_fix_res = w_rem;
            default:          w_fix_res = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (r_cnt == CNTW'(1)) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: begin
                if (w_accept) w_next_state = w_special ? ST_DONE : ST_CALC;
                else          w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (flush) w_next_state = ST_IDLE;
    end

    // Datapath: operand load, iteration, and result/tag capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_op      <= OP_MUL;
            r_neg     <= 1'b0;
            r_tag     <= '0;
            r_result  <= '0;
            r_tag_out <= '0;
        end else if (w_accept) begin
            r_cnt <= CNTW'(XLEN);
            r_op  <= op;
            r_neg <= w_neg;
            r_tag <= tag_in;
            if (op[2]) begin
                r_acc <= {{XLEN{1'b0}}, w_a_mag};
                r_opb <= w_b_mag;
            end else begin
                r_acc <= {{XLEN{1'b0}}, w_b_mag};
                r_opb <= w_a_mag;
            end
            if (w_special) begin
                r_result  <= w_special_res;
                r_tag_out <= tag_in;
            end
        end else if (!flush) begin
            if (r_state == ST_CALC) begin
                r_acc <= w_step;
                r_cnt <= r_cnt - CNTW'(1);
            end else if (r_state == ST_FIX) begin
                r_result  <= w_fix_res;
                r_tag_out <= r_tag;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: 32-bit and 64-bit instances, hand-computed results.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        s_start, s_flush;
    logic [2:0]  s_op;
    logic [31:0] s_a, s_b;
    logic [4:0]  s_tag;
    logic        s_ready, s_done;
    logic [31:0] s_result;
    logic [4:0]  s_tag_out;

    logic        d_start, d_flush;
    logic [2:0]  d_op;
    logic [63:0] d_a, d_b;
    logic [4:0]  d_tag;
    logic        d_ready, d_done;
    logic [63:0] d_result;
    logic [4:0]  d_tag_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_res32;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32), .TAGW(5)) u_dut32 (
        .clk(clk), .reset_n(reset_n), .start(s_start), .op(s_op), .a(s_a), .b(s_b),
        .tag_in(s_tag), .flush(s_flush), .ready(s_ready), .done(s_done),
        .result(s_result), .tag_out(s_tag_out)
    );

    mul_div_unit #(.XLEN(64), .TAGW(5)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .start(d_start), .op(d_op), .a(d_a), .b(d_b),
        .tag_in(d_tag), .flush(d_flush), .ready(d_ready), .done(d_done),
        .result(d_result), .tag_out(d_tag_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op (caller sits just after a clock edge); exp_lat = edges after the
    // accepting edge until done is seen (0 means done right after the accept edge).
    task automatic run_op(input bit w64, input string name, input logic [2:0] op,
                          input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                          input logic [63:0] exp, input int exp_lat);
        int  lat;
        bit  seen;
        check({name, "_ready"}, 64'(w64 ? d_ready : s_ready), 64'd1);
        if (w64) begin
            d_op = op; d_a = a; d_b = b; d_tag = tag; d_start = 1'b1;
        end else begin
            s_op = op; s_a = a[31:0]; s_b = b[31:0]; s_tag = tag; s_start = 1'b1;
        end
        @(posedge clk); #1;
        s_start = 1'b0;
        d_start = 1'b0;
        lat  = 0;
        seen = w64 ? d_done : s_done;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            seen = w64 ? d_done : s_done;
        end
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        if (w64) begin
            check({name, "_res"}, d_result, exp);
            check({name, "_tag"}, 64'(d_tag_out), 64'(tag));
        end else begin
            check({name, "_res"}, {32'd0, s_result}, exp);
            check({name, "_tag"}, 64'(s_tag_out), 64'(tag));
            last_res32 = exp[31:0];
        end
    endtask

    // Watch the 32-bit unit for a number of edges and require no done pulse
    task automatic watch_no_done(input string name, input int cycles);
        int n_done = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (s_done) n_done++;
        end
        check({name, "_nodone"}, 64'(n_done), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        s_start = 1'b0; s_flush = 1'b0; s_op = 3'd0; s_a = '0; s_b = '0; s_tag = '0;
        d_start = 1'b0; d_flush = 1'b0; d_op = 3'd0; d_a = '0; d_b = '0; d_tag = '0;
        last_res32 = '0;
        #1;
        check("rst_done",   64'(s_done),    64'd0);
        check("rst_result", {32'd0, s_result}, 64'd0);
        check("rst_tag",    64'(s_tag_out), 64'd0);
        check("rst_ready",  64'(s_ready),   64'd1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Multiply family
        run_op(1'b0, "mul",    3'b000, 64'h7,        64'hFFFFFFFD, 5'd3, 64'hFFFFFFEB, 33);
        run_op(1'b0, "mulh",   3'b001, 64'h80000000, 64'h80000000, 5'd4, 64'h40000000, 33);
        run_op(1'b0, "mulhu",  3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd5, 64'hFFFFFFFE, 33);
        run_op(1'b0, "mulhsu", 3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd6, 64'hFFFFFFFF, 33);
        run_op(1'b0, "mul2",   3'b000, 64'h12345678, 64'h10,       5'd16, 64'h23456780, 33);
        // Divide family
        run_op(1'b0, "div",    3'b100, 64'hFFFFFFF9, 64'h2,        5'd7, 64'hFFFFFFFD, 33);
        run_op(1'b0, "rem",    3'b110, 64'hFFFFFFF9, 64'h2,        5'd8, 64'hFFFFFFFF, 33);
        run_op(1'b0, "divu",   3'b101, 64'd100,      64'd7,        5'd9, 64'd14,       33);
        run_op(1'b0, "remu",   3'b111, 64'd100,      64'd7,        5'd10, 64'd2,       33);
        run_op(1'b0, "divu_m1",3'b101, 64'h80000000, 64'hFFFFFFFF, 5'd17, 64'h0,       33);
        run_op(1'b0, "remu_m1",3'b111, 64'h80000000, 64'hFFFFFFFF, 5'd18, 64'h80000000, 33);
        // Special cases complete on the accepting edge
        run_op(1'b0, "div0",   3'b100, 64'd5,        64'd0,        5'd11, 64'hFFFFFFFF, 0);
        run_op(1'b0, "rem0",   3'b110, 64'd5,        64'd0,        5'd12, 64'd5,        0);
        run_op(1'b0, "divu0",  3'b101, 64'd9,        64'd0,        5'd15, 64'hFFFFFFFF, 0);
        run_op(1'b0, "remu0",  3'b111, 64'd7,        64'd0,        5'd19, 64'd7,        0);
        run_op(1'b0, "div_ov", 3'b100, 64'h80000000, 64'hFFFFFFFF, 5'd13, 64'h80000000, 0);
        run_op(1'b0, "rem_ov", 3'b110, 64'h80000000, 64'hFFFFFFFF, 5'd14, 64'h0,        0);
        // Back-to-back from DONE into a full-length op
        run_op(1'b0, "b2b",    3'b000, 64'd6,        64'd7,        5'd20, 64'd42,       33);

        // Flush on the 10th CALC cycle
        @(posedge clk); #1;
        s_op = 3'b000; s_a = 32'd3; s_b = 32'd5; s_tag = 5'd21; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        s_flush = 1'b1;
        @(posedge clk); #1;
        s_flush = 1'b0;
        check("flush_ready", 64'(s_ready), 64'd1);
        watch_no_done("flush", 40);
        check("flush_hold", {32'd0, s_result}, {32'd0, last_res32});

        // Flush and start together: start dropped
        s_op = 3'b000; s_a = 32'd3; s_b = 32'd5; s_tag = 5'd22; s_start = 1'b1; s_flush = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; s_flush = 1'b0;
        check("fs_ready", 64'(s_ready), 64'd1);
        watch_no_done("fs", 40);

        // Reset mid-CALC
        s_op = 3'b000; s_a = 32'd3; s_b = 32'd5; s_tag = 5'd23; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre_rst_busy", 64'(s_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("mrst_done",   64'(s_done),       64'd0);
        check("mrst_result", {32'd0, s_result}, 64'd0);
        check("mrst_ready",  64'(s_ready),      64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        watch_no_done("mrst", 40);
        run_op(1'b0, "post_rst", 3'b101, 64'd1000, 64'd10, 5'd24, 64'd100, 33);

        // 64-bit instance
        run_op(1'b1, "mul64",    3'b000, 64'h7, 64'hFFFFFFFFFFFFFFFD, 5'd3, 64'hFFFFFFFFFFFFFFEB, 65);
        run_op(1'b1, "mulh64",   3'b001, 64'h8000000000000000, 64'h8000000000000000, 5'd4,
               64'h4000000000000000, 65);
        run_op(1'b1, "mulhu64",  3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd5,
               64'hFFFFFFFFFFFFFFFE, 65);
        run_op(1'b1, "mulhsu64", 3'b010, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6,
               64'hFFFFFFFFFFFFFFFF, 65);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
